// File: rtl/music_pkg.sv
// Shared constants and types for the tone generator / envelope chain.
// Defaults here are the power-on configuration of the music path.
package music_pkg;

  localparam int SAMPLE_BITS_DEF   = 7;
  localparam int LEVEL_BITS_DEF    = 8;
  localparam int ATTACK_STEP_DEF   = 16;
  localparam int DECAY_STEP_DEF    = 4;
  localparam int SUSTAIN_LEVEL_DEF = 192;
  localparam int RELEASE_STEP_DEF  = 8;
  localparam int RATE_DIV_DEF      = 4;

  localparam int MID = 1 << (SAMPLE_BITS_DEF - 1);

  typedef enum logic [2:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_DECAY,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_e;

  function automatic int mid_of(input int bits);
    return 1 << (bits - 1);
  endfunction

endpackage

// File: rtl/env_scale.sv
// Combinational envelope scaler: centres the sample on mid-scale, multiplies
// by the level, floors by 2**LEVEL_BITS and clamps back into sample range.
module env_scale
  import music_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int LEVEL_BITS  = LEVEL_BITS_DEF
) (
  input  logic [SAMPLE_BITS-1:0] i_sample,
  input  logic [LEVEL_BITS-1:0]  i_level,
  output logic [SAMPLE_BITS-1:0] o_scaled
);

  localparam int DW    = SAMPLE_BITS + 1;
  localparam int PW    = DW + LEVEL_BITS;
  localparam int MID_V = mid_of(SAMPLE_BITS);
  localparam int MAX_V = (1 << SAMPLE_BITS) - 1;

  localparam logic signed [DW-1:0] MID_D = DW'(MID_V);
  localparam logic signed [PW-1:0] MID_P = PW'(MID_V);
  localparam logic signed [PW-1:0] MAX_P = PW'(MAX_V);

  logic signed [DW-1:0] w_diff;
  logic signed [PW-1:0] w_diff_x;
  logic signed [PW-1:0] w_level_x;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_sum;

  assign w_diff    = $signed({1'b0, i_sample}) - MID_D;
  assign w_diff_x  = {{LEVEL_BITS{w_diff[DW-1]}}, w_diff};
  assign w_level_x = {{(PW - LEVEL_BITS){1'b0}}, i_level};
  assign w_prod    = w_diff_x * w_level_x;
  // Arithmetic shift floors negative products, so level 255 maps 0 -> 0.
  assign w_sum     = (w_prod >>> LEVEL_BITS) + MID_P;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missing
    // else branch would silently infer a latch.
    o_scaled = w_sum[SAMPLE_BITS-1:0];
    if (w_sum < 0) begin
      o_scaled = '0;
    end else if (w_sum > MAX_P) begin
      o_scaled = SAMPLE_BITS'(MAX_V);
    end
  end

endmodule

// File: rtl/note_envelope.sv
// ADSR amplitude envelope between the oscillator and the PWM comparator.
// All activity is gated by sample_tick; the scaled sample is registered.
module note_envelope
  import music_pkg::*;
#(
  parameter int SAMPLE_BITS   = SAMPLE_BITS_DEF,
  parameter int LEVEL_BITS    = LEVEL_BITS_DEF,
  parameter int ATTACK_STEP   = ATTACK_STEP_DEF,
  parameter int DECAY_STEP    = DECAY_STEP_DEF,
  parameter int SUSTAIN_LEVEL = SUSTAIN_LEVEL_DEF,
  parameter int RELEASE_STEP  = RELEASE_STEP_DEF,
  parameter int RATE_DIV      = RATE_DIV_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_tick,
  input  logic                   gate,
  input  logic [SAMPLE_BITS-1:0] sample_in,
  output logic [SAMPLE_BITS-1:0] sample_out,
  output logic [LEVEL_BITS-1:0]  level,
  output logic                   busy
);

  localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int LW    = LEVEL_BITS + 1;
  localparam int MID_V = mid_of(SAMPLE_BITS);

  localparam logic [LW-1:0]    L_MAX    = LW'((1 << LEVEL_BITS) - 1);
  localparam logic [LW-1:0]    A_STEP   = LW'(ATTACK_STEP);
  localparam logic [LW-1:0]    D_STEP   = LW'(DECAY_STEP);
  localparam logic [LW-1:0]    R_STEP   = LW'(RELEASE_STEP);
  localparam logic [LW-1:0]    L_SUS    = LW'(SUSTAIN_LEVEL);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);

  env_state_e             r_state;
  env_state_e             w_next_state;
  logic [LEVEL_BITS-1:0]  r_level;
  logic [LEVEL_BITS-1:0]  w_next_level;
  logic [DIV_W-1:0]       r_div;
  logic                   r_gate_q;
  logic [SAMPLE_BITS-1:0] r_sample_out;
  logic [SAMPLE_BITS-1:0] w_scaled;

  logic          w_rise;
  logic          w_fall;
  logic          w_rate_tick;
  logic [LW-1:0] w_att_sum;
  logic [LW-1:0] w_dec_diff;
  logic [LW-1:0] w_rel_diff;

  assign w_rise      = gate & ~r_gate_q;
  assign w_fall      = ~gate & r_gate_q;
  assign w_rate_tick = (r_div == DIV_LAST);

  // One bit wider so the carry/borrow is visible for clamping.
  assign w_att_sum  = {1'b0, r_level} + A_STEP;
  assign w_dec_diff = {1'b0, r_level} - D_STEP;
  assign w_rel_diff = {1'b0, r_level} - R_STEP;

  env_scale #(
    .SAMPLE_BITS(SAMPLE_BITS),
    .LEVEL_BITS (LEVEL_BITS)
  ) u_env_scale (
    .i_sample(sample_in),
    .i_level (r_level),
    .o_scaled(w_scaled)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state <= ENV_IDLE;
    end else if (sample_tick) begin
      r_state <= w_next_state;
    end
  end

  // Gate edges take priority over the rate step on the same tick.
  always_comb begin
    w_next_state = r_state;
    w_next_level = r_level;
    if (w_rise) begin
      w_next_state = ENV_ATTACK;
    end else if (w_fall) begin
      if (r_state inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN}) begin
        w_next_state = ENV_RELEASE;
      end
    end else if (w_rate_tick) begin
      case (r_state)
        ENV_ATTACK: begin
          if (w_att_sum >= L_MAX) begin
            w_next_level = L_MAX[LEVEL_BITS-1:0];
            w_next_state = ENV_DECAY;
          end else begin
            w_next_level = w_att_sum[LEVEL_BITS-1:0];
          end
        end
        ENV_DECAY: begin
          if (w_dec_diff[LW-1] || (w_dec_diff <= L_SUS)) begin
            w_next_level = L_SUS[LEVEL_BITS-1:0];
            w_next_state = ENV_SUSTAIN;
          end else begin
            w_next_level = w_dec_diff[LEVEL_BITS-1:0];
          end
        end
        ENV_RELEASE: begin
          if (w_rel_diff[LW-1] || (w_rel_diff == '0)) begin
            w_next_level = '0;
            w_next_state = ENV_IDLE;
          end else begin
            w_next_level = w_rel_diff[LEVEL_BITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Divider keeps running across gate edges so rate steps stay evenly spaced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level      <= '0;
      r_div        <= '0;
      r_gate_q     <= 1'b0;
      r_sample_out <= SAMPLE_BITS'(MID_V);
    end else if (sample_tick) begin
      r_level      <= w_next_level;
      r_div        <= w_rate_tick ? '0 : r_div + 1'b1;
      r_gate_q     <= gate;
      r_sample_out <= w_scaled;
    end
  end

  always_comb begin
    sample_out = r_sample_out;
    level      = r_level;
    busy       = (r_state != ENV_IDLE);
  end

endmodule
